// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache for the Memory-stage port.
// Stalls the core on misses and stores while it talks to backing memory over req/ack.

module dcache_responder_line #(
  parameter int TAG_W = 26
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_fill,
  input  logic             i_wr,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [31:0]      i_fill_data,
  input  logic [31:0]      i_wr_data,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic [31:0]      o_data
);
  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_valid <= 1'b0;
    else if (i_fill) r_valid <= 1'b1;
  end

  // Tag/data need no reset: they are meaningless until valid is set by a fill.
  always_ff @(posedge i_clk) begin
    if (i_fill) begin
      r_tag  <= i_tag;
      r_data <= i_fill_data;
    end else if (i_wr) begin
      r_data <= i_wr_data;
    end
  end

  assign o_valid = r_valid;
  assign o_tag   = r_tag;
  assign o_data  = r_data;
endmodule

module dcache_responder #(
  parameter int SETS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_stall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_hits, r_misses;

  logic [SETS-1:0]             w_valid, w_fill, w_wr;
  logic [SETS-1:0][TAG_W-1:0]  w_tags;
  logic [SETS-1:0][31:0]       w_datas;

  logic [IDX_W-1:0] w_idx, w_ridx;
  logic [TAG_W-1:0] w_tag, w_rtag;
  logic             w_hit, w_fill_any, w_wr_any;
  logic             w_stall, w_mem_req, w_latch, w_hit_inc, w_miss_inc;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_idx    = i_cpu_addr[IDX_W+1:2];
  assign w_tag    = i_cpu_addr[31:IDX_W+2];
  assign w_ridx   = r_addr[IDX_W+1:2];
  assign w_rtag   = r_addr[31:IDX_W+2];
  assign w_unused = &{1'b0, i_cpu_addr[1:0]};

  assign w_hit = i_cpu_req & w_valid[w_idx] & (w_tags[w_idx] == w_tag);

  assign w_fill_any = !i_rst & (r_state == S_REFILL) & i_mem_ack;
  assign w_wr_any   = !i_rst & (r_state == S_IDLE) & i_cpu_req & i_cpu_we & w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < SETS; gi++) begin : g_line
      assign w_fill[gi] = w_fill_any & (w_ridx == IDX_W'(gi));
      assign w_wr[gi]   = w_wr_any & (w_idx == IDX_W'(gi));
      dcache_responder_line #(.TAG_W(TAG_W)) u_line (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_fill      (w_fill[gi]),
        .i_wr        (w_wr[gi]),
        .i_tag       (w_rtag),
        .i_fill_data (i_mem_rdata),
        .i_wr_data   (i_cpu_wdata),
        .o_valid     (w_valid[gi]),
        .o_tag       (w_tags[gi]),
        .o_data      (w_datas[gi])
      );
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_addr <= {i_cpu_addr[31:2], 2'b00};
        if (i_cpu_we) r_wdata <= i_cpu_wdata;
      end
      if (w_hit_inc)  r_hits   <= r_hits + 32'd1;
      if (w_miss_inc) r_misses <= r_misses + 32'd1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_stall    = 1'b0;
    w_mem_req  = 1'b0;
    w_rdata    = '0;
    w_latch    = 1'b0;
    w_hit_inc  = 1'b0;
    w_miss_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cpu_req) begin
          if (i_cpu_we) begin
            w_stall = 1'b1;
            w_latch = 1'b1;
            w_next  = S_WRITE;
          end else if (w_hit) begin
            w_rdata   = w_datas[w_idx];
            w_hit_inc = 1'b1;
          end else begin
            w_stall    = 1'b1;
            w_latch    = 1'b1;
            w_miss_inc = 1'b1;
            w_next     = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        w_mem_req = 1'b1;
        w_stall   = !i_mem_ack;
        if (i_mem_ack) begin
          w_rdata = i_mem_rdata;
          w_next  = S_IDLE;
        end
      end
      S_WRITE: begin
        w_mem_req = 1'b1;
        w_stall   = !i_mem_ack;
        if (i_mem_ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Reset abandons any in-flight transaction and ignores the core in the same cycle.
    if (i_rst) begin
      w_stall    = 1'b0;
      w_mem_req  = 1'b0;
      w_rdata    = '0;
      w_hit_inc  = 1'b0;
      w_miss_inc = 1'b0;
    end
  end

  assign o_cpu_rdata  = w_rdata;
  assign o_cpu_stall  = w_stall;
  assign o_mem_req    = w_mem_req;
  assign o_mem_we     = w_mem_req & (r_state == S_WRITE);
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;
  assign o_hit_count  = r_hits;
  assign o_miss_count = r_misses;
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: stimulus pushes expected load data and memory
// transactions into queues; negedge monitors pop and compare as the DUT presents them.

module tb_dcache_responder;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mtx_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, hit_count, miss_count;

  logic        auto_en, auto_ack, force_ack;
  int          ack_delay, ack_cnt;
  logic [31:0] tb_mem_data;

  int checks = 0;
  int fails  = 0;

  logic [31:0] rd_q[$];
  mtx_t        mem_q[$];
  logic [31:0] mon_rd;
  mtx_t        mon_mt;

  always #5 clk = ~clk;

  assign mem_ack   = auto_ack | force_ack;
  assign mem_rdata = tb_mem_data;

  dcache_responder #(.SETS(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cpu_req    (cpu_req),
    .i_cpu_we     (cpu_we),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .o_cpu_rdata  (cpu_rdata),
    .o_cpu_stall  (cpu_stall),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_ack    (mem_ack),
    .i_mem_rdata  (mem_rdata),
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Backing memory: ack ack_delay cycles after mem_req rises.
  initial begin
    auto_ack = 1'b0;
    ack_cnt  = 0;
    forever begin
      @(posedge clk);
      #2;
      if (auto_en && mem_req) begin
        if (ack_cnt == ack_delay) begin
          auto_ack = 1'b1;
          ack_cnt  = 0;
        end else begin
          auto_ack = 1'b0;
          ack_cnt++;
        end
      end else begin
        auto_ack = 1'b0;
        ack_cnt  = 0;
      end
    end
  end

  // Load-data monitor.
  always @(negedge clk) begin
    if (!rst && cpu_req && !cpu_we && !cpu_stall) begin
      if (rd_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL rd_unexpected actual=%h expected=none", cpu_rdata);
      end else begin
        mon_rd = rd_q.pop_front();
        chk("cpu_rdata", cpu_rdata, mon_rd);
      end
    end
  end

  // Memory-transaction monitor: checks every request cycle (stability), pops on ack.
  always @(negedge clk) begin
    if (!rst && mem_req) begin
      if (mem_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL mem_unexpected actual=%h expected=none", mem_addr);
      end else begin
        mon_mt = mem_q[0];
        chk("mem_we", {31'd0, mem_we}, {31'd0, mon_mt.we});
        chk("mem_addr", mem_addr, mon_mt.addr);
        if (mon_mt.we) chk("mem_wdata", mem_wdata, mon_mt.wdata);
        if (mem_ack) mem_q.pop_front();
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input int dly, input int exp_stall);
    int n;
    bit done;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = we ? d : 32'h0;
    ack_delay = dly;
    tb_mem_data = we ? 32'h0 : d;
    if (!we) rd_q.push_back(d);
    if (exp_stall > 0) mem_q.push_back('{we: we, addr: {a[31:2], 2'b00}, wdata: (we ? d : 32'h0)});
    n = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (cpu_stall) n++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL access_timeout actual=stalled expected=done addr=%h", a);
    end
    chk(we ? "store_stall_cycles" : "load_stall_cycles", n, exp_stall);
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic counters(input int h, input int m);
    @(negedge clk);
    chk("hit_count", hit_count, h);
    chk("miss_count", miss_count, m);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = 32'h0;
    auto_en = 1'b1; force_ack = 1'b0; ack_delay = 0; tb_mem_data = 32'h0;
    @(negedge clk);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0;
    counters(0, 0);
    @(posedge clk); #1;

    // Miss then hit, store hit, store miss (no allocate), conflicts.
    access(1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 3, 4);
    access(1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 0, 0);
    counters(1, 1);
    @(posedge clk); #1;
    access(1'b1, 32'h0000_0040, 32'hCAFE_0001, 2, 3);
    access(1'b0, 32'h0000_0040, 32'hCAFE_0001, 0, 0);
    access(1'b1, 32'h0000_0080, 32'h1234_5678, 1, 2);
    access(1'b0, 32'h0000_0040, 32'hCAFE_0001, 0, 0);
    access(1'b0, 32'h0000_0080, 32'h1234_5678, 0, 1);
    access(1'b0, 32'h0000_0080, 32'h1234_5678, 0, 0);
    counters(4, 2);
    @(posedge clk); #1;
    access(1'b0, 32'h0000_0040, 32'hCAFE_0001, 1, 2);
    access(1'b0, 32'h0000_0440, 32'h4400_0000, 2, 3);
    access(1'b0, 32'h0000_0040, 32'hCAFE_0001, 0, 1);
    access(1'b0, 32'h0000_0044, 32'h4444_4444, 0, 1);
    access(1'b0, 32'h0000_0043, 32'hCAFE_0001, 0, 0);
    counters(5, 6);

    // Stray ack while idle.
    @(posedge clk); #1;
    force_ack = 1'b1; tb_mem_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("idle_ack_rdata", cpu_rdata, 32'd0);
    chk("idle_ack_stall", {31'd0, cpu_stall}, 32'd0);
    chk("idle_ack_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    counters(5, 6);
    @(posedge clk); #1;
    access(1'b0, 32'h0000_0040, 32'hCAFE_0001, 0, 0);
    counters(6, 6);

    // Reset in the middle of a refill.
    @(posedge clk); #1;
    auto_en = 1'b0;
    mem_q.push_back('{we: 1'b0, addr: 32'h48, wdata: 32'h0});
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h48;
    @(posedge clk);
    @(negedge clk);
    chk("refill_mem_req", {31'd0, mem_req}, 32'd1);
    chk("refill_stall", {31'd0, cpu_stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_q.delete();
    @(negedge clk);
    chk("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("post_rst_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk); #1;
    force_ack = 1'b1; tb_mem_data = 32'h5555_AAAA;
    @(negedge clk);
    chk("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
    chk("late_ack_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    force_ack = 1'b0; auto_en = 1'b1;
    counters(0, 0);
    @(posedge clk); #1;
    access(1'b0, 32'h0000_0040, 32'hCAFE_0001, 1, 2);
    access(1'b0, 32'h0000_0048, 32'h4848_4848, 0, 1);
    access(1'b0, 32'h0000_0040, 32'hCAFE_0001, 0, 0);
    counters(1, 2);

    @(negedge clk);
    chk("rd_q_empty", rd_q.size(), 32'd0);
    chk("mem_q_empty", mem_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/dcache_responder.md
# dcache_responder

Direct-mapped, write-through, no-write-allocate data cache serving the Memory-stage load/store port of the pipelined core. It is the responder for the core's data-memory requests: it stalls the pipeline on misses and writes, and acts as initiator toward a slower backing data memory through a req/ack handshake. It replaces the zero-latency combinational data memory path between the Execute->Mem and Mem->Write pipeline registers.

## Interface
- SETS, 16: number of one-word lines; power of two, ≥2; IDX_W = log2(SETS)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- cpu_req  in  1  Memory-stage access valid
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address; bits [1:0] ignored (word accesses only)
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data
- cpu_stall  out  1  hold all pipeline registers this cycle
- mem_req  out  1  backing-memory request valid
- mem_we  out  1  backing-memory write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  write data
- mem_ack  in  1  backing memory completes request this cycle
- mem_rdata  in  32  read data, valid when mem_ack and !mem_we
- hit_count  out  32  load hits since reset
- miss_count  out  32  load misses since reset

## Operation
- Address split: index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2]. Per line: valid bit, tag, 32-bit data.
- hit = cpu_req & valid[index] & (tag_array[index] == tag).
- FSM states IDLE, REFILL, WRITE.
- IDLE, no cpu_req: cpu_stall=0, mem_req=0.
- IDLE, load hit: cpu_rdata = line data (combinational), cpu_stall=0, hit_count+1.
- IDLE, load miss: cpu_stall=1; latch address; miss_count+1; -> REFILL.
- IDLE, store: cpu_stall=1; latch address and data; on hit, line data updated this edge (on miss, line untouched); -> WRITE.
- REFILL: mem_req=1, mem_we=0, mem_addr=latched. cpu_stall = !mem_ack. On mem_ack: cpu_rdata = mem_rdata (forwarded), line written {valid=1, tag, mem_rdata}; -> IDLE.
- WRITE: mem_req=1, mem_we=1, mem_addr/mem_wdata = latched. cpu_stall = !mem_ack. On mem_ack -> IDLE.
- mem_addr, mem_we, mem_wdata held stable while mem_req=1 until the mem_ack cycle; mem_ack while mem_req=0 is ignored.
- cpu_rdata = 0 whenever no load hit and no refill ack this cycle.
- Counters wrap modulo 2^32; IDLE store does not count.
- Core holds cpu_req/cpu_addr/cpu_we/cpu_wdata stable while cpu_stall=1. Inputs are sampled only in IDLE.

## Timing
- Reset values: state IDLE, all valid bits 0, cpu_stall 0, cpu_rdata 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, hit_count 0, miss_count 0. All valid bits cleared in the single reset cycle.
- Reset mid-REFILL/WRITE: transaction abandoned; mem_req=0 from the next cycle; a late mem_ack is ignored; no line written.
- cpu_req during rst is ignored; counters do not increment.
- Load hit: 0 extra cycles. Load miss: stall cycles = 1 (IDLE) + cycles until mem_ack; data delivered in ack cycle.
- Store: same stall profile as a miss, whether it hits or not.
- Back-to-back: the request presented in the cycle after the ack cycle is evaluated in IDLE; a load to the just-refilled line hits.
- Same-index conflicting tag on refill overwrites the line (direct-mapped replacement).

## Test plan
- Reset, then load 0x0000_0040 with mem_ack 3 cycles after mem_req and mem_rdata=0xDEAD_BEEF -> stall high 4 cycles, cpu_rdata=0xDEAD_BEEF in ack cycle, miss_count=1; repeat load -> stall 0, same data, hit_count=1.
- Store 0xCAFE_0001 to 0x40 (hit) -> mem_req/mem_we=1, mem_addr=0x40, mem_wdata held until ack; next load 0x40 hits, returns 0xCAFE_0001.
- Store to 0x80 (miss) then load 0x80 -> store causes no allocation; load misses (miss_count+1) and refills.
- SETS=16: load 0x40 then 0x440 (same index 0, different tag) -> both miss; load 0x40 again misses.
- Assert rst during REFILL with mem_ack 2 cycles later -> mem_req 0 next cycle, stall 0, ack ignored, load 0x40 afterwards misses.
- mem_ack pulsed while idle -> no state change, no counter change, cpu_rdata 0.
